deck_shuffler: RTL and testbench

- Upstream master for the card-memory RAM: owns its write port and both read-address ports while active.
- On `start`, writes an ordered deck (card codes 0..NUM_CARDS-1) into consecutive RAM words from DECK_BASE.
- Then performs an in-place Fisher-Yates shuffle, driven by a 16-bit Galois LFSR.
- Pulses `done` when the deck is ready for the dealer logic to consume.

---
 rtl/card_pkg.sv | 31 +++
 rtl/galois_lfsr16.sv | 38 +++
 rtl/deck_shuffler.sv | 160 ++++++++++++++++
 tb/tb_deck_shuffler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared definitions for the card-deck blocks: LFSR constants, FSM state
// encoding and a small helper that computes the rejection-sampling mask.
package card_pkg;

    localparam int          NUM_CARDS_DEFAULT = 52;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        PICK    = 3'd2,
        READ    = 3'd3,
        CAPTURE = 3'd4,
        WR_I    = 3'd5,
        WR_J    = 3'd6,
        DONE    = 3'd7
    } state_t;

    // Smallest all-ones mask covering v, i.e. 2^clog2(v+1)-1.
    function automatic logic [15:0] range_mask(input logic [15:0] v);
        logic [15:0] m;
        m = v;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        return m;
    endfunction

endpackage

// File: rtl/galois_lfsr16.sv
// 16-bit right-shifting Galois LFSR with synchronous load and advance enable.
// Load has priority over advance.
module galois_lfsr16
    import card_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        advance,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    // Next value: load a seed, or shift right and fold in the taps when the LSB is 1.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (advance) begin
            q_d = q_q[0] ? ((q_q >> 1) ^ LFSR_TAPS) : (q_q >> 1);
        end
    end

    // State register; reset restores the default seed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= LFSR_DEFAULT_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/deck_shuffler.sv
// Fills NUM_CARDS RAM slots with 0..NUM_CARDS-1, then Fisher-Yates shuffles
// them in place using rejection sampling on a Galois LFSR.
// Control: start is taken only in IDLE; busy is high from FILL through WR_J;
// done is a one-cycle pulse in DONE with busy already low.
module deck_shuffler
    import card_pkg::*;
#(
    parameter  int DATA_WIDTH    = 32,
    parameter  int ADDRESS_WIDTH = 12,
    parameter  int DECK_BASE     = 0,
    parameter  int NUM_CARDS     = NUM_CARDS_DEFAULT,
    localparam int IDX_W         = $clog2(NUM_CARDS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [15:0]              seed,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [ADDRESS_WIDTH-1:0] mem_addr2,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut2
);

    localparam logic [ADDRESS_WIDTH-1:0] BASE_A = ADDRESS_WIDTH'(DECK_BASE);
    localparam logic [IDX_W-1:0]         LAST   = IDX_W'(NUM_CARDS - 1);

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        k_q, k_d;
    logic [IDX_W-1:0]        i_q, i_d;
    logic [IDX_W-1:0]        j_q, j_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;

    logic        lfsr_load;
    logic [15:0] lfsr_seed;
    logic [15:0] lfsr_q;
    logic [15:0] cand;
    logic        cand_ok;

    // A zero seed would lock the LFSR, so it is replaced by the default.
    assign lfsr_seed = (seed == 16'h0) ? LFSR_DEFAULT_SEED : seed;

    // Candidate swap partner for slot i; rejected when it lands above i.
    assign cand    = lfsr_q & range_mask(16'(i_q));
    assign cand_ok = (cand <= 16'(i_q));

    galois_lfsr16 u_lfsr (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (lfsr_load),
        .load_val (lfsr_seed),
        .advance  (busy),
        .q        (lfsr_q)
    );

    // Next-state, index updates and RAM bus drive for each phase of the shuffle.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        i_d        = i_q;
        j_d        = j_q;
        a_d        = a_q;
        b_d        = b_q;
        lfsr_load  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_wEn    = 1'b0;
        mem_addr   = '0;
        mem_addr2  = '0;
        mem_dataIn = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    lfsr_load = 1'b1;
                    k_d       = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                busy       = 1'b1;
                mem_wEn    = 1'b1;
                mem_addr   = BASE_A + ADDRESS_WIDTH'(k_q);
                mem_dataIn = DATA_WIDTH'(k_q);
                if (k_q == LAST) begin
                    i_d     = LAST;
                    state_d = PICK;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            PICK: begin
                busy = 1'b1;
                if (cand_ok) begin
                    j_d     = IDX_W'(cand);
                    state_d = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                mem_addr  = BASE_A + ADDRESS_WIDTH'(i_q);
                mem_addr2 = BASE_A + ADDRESS_WIDTH'(j_q);
                state_d   = CAPTURE;
            end
            CAPTURE: begin
                busy    = 1'b1;
                a_d     = mem_dataOut;
                b_d     = mem_dataOut2;
                state_d = WR_I;
            end
            WR_I: begin
                busy       = 1'b1;
                mem_wEn    = 1'b1;
                mem_addr   = BASE_A + ADDRESS_WIDTH'(i_q);
                mem_dataIn = b_q;
                state_d    = WR_J;
            end
            WR_J: begin
                busy       = 1'b1;
                mem_wEn    = 1'b1;
                mem_addr   = BASE_A + ADDRESS_WIDTH'(j_q);
                mem_dataIn = a_q;
                if (i_q == IDX_W'(1)) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q - IDX_W'(1);
                    state_d = PICK;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, index counters and swap latches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule

// File: tb/tb_deck_shuffler.sv
// Bench for deck_shuffler: a 52-card instance and a 2-card instance, each on
// its own synchronous-read RAM model, compared against a Fisher-Yates model.
module tb_deck_shuffler;

  localparam int N      = 52;
  localparam int N2     = 2;
  localparam int BASE2  = 100;
  localparam int BUDGET = 2000;
  localparam int NVEC   = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, start2;
  logic [15:0] seed, seed2;
  logic        busy, done, wen;
  logic [11:0] addr, addr2;
  logic [31:0] din, dout, dout2;
  logic        busy_b, done_b, wen_b;
  logic [11:0] addr_b, addr2_b;
  logic [31:0] din_b, dout_b, dout2_b;

  logic [31:0] ram  [4096];
  logic [31:0] ram2 [4096];
  logic        ram_clr;

  deck_shuffler #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .DECK_BASE(0), .NUM_CARDS(N)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .seed(seed), .busy(busy), .done(done),
    .mem_wEn(wen), .mem_addr(addr), .mem_addr2(addr2), .mem_dataIn(din),
    .mem_dataOut(dout), .mem_dataOut2(dout2)
  );

  deck_shuffler #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12), .DECK_BASE(BASE2), .NUM_CARDS(N2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .seed(seed2), .busy(busy_b), .done(done_b),
    .mem_wEn(wen_b), .mem_addr(addr_b), .mem_addr2(addr2_b), .mem_dataIn(din_b),
    .mem_dataOut(dout_b), .mem_dataOut2(dout2_b)
  );

  // RAM models: 1-cycle read; a write cycle returns garbage on the read ports.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int a = 0; a < 4096; a++) begin
        ram[a]  <= '0;
        ram2[a] <= '0;
      end
    end else begin
      if (wen) begin
        ram[addr] <= din;
        dout      <= 32'hDEADBEEF;
        dout2     <= 32'hDEADBEEF;
      end else begin
        dout  <= ram[addr];
        dout2 <= ram[addr2];
      end
      if (wen_b) begin
        ram2[addr_b] <= din_b;
        dout_b       <= 32'hDEADBEEF;
        dout2_b      <= 32'hDEADBEEF;
      end else begin
        dout_b  <= ram2[addr_b];
        dout2_b <= ram2[addr2_b];
      end
    end
  end

  // Bus monitors: write count, done pulses, and any bus activity while not busy.
  int wr_cnt, done_cnt, viol_cnt, wr_cnt2, done_cnt2, viol_cnt2;
  always @(negedge clk) begin
    if (wen) wr_cnt++;
    if (done) done_cnt++;
    if (!busy && (wen || addr != 0 || addr2 != 0 || din != 0)) viol_cnt++;
    if (wen_b) wr_cnt2++;
    if (done_b) done_cnt2++;
    if (!busy_b && (wen_b || addr_b != 0 || addr2_b != 0 || din_b != 0)) viol_cnt2++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: plain Fisher-Yates, with one LFSR step per clock of the run.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_run(input logic [15:0] s, input int n, output int cyc,
                           output logic [2047:0] img);
    int deck [256];
    logic [15:0] l;
    int m, cand, j, t;
    l   = (s == 16'h0) ? 16'hACE1 : s;
    cyc = 0;
    img = '0;
    for (int k = 0; k < n; k++) begin
      deck[k] = k;
      l = lfsr_step(l);
      cyc++;
    end
    for (int i = n - 1; i >= 1; i--) begin
      m = 1;
      while (m < i + 1) m = m * 2;
      forever begin
        cand = int'(l) % m;
        l = lfsr_step(l);
        cyc++;
        if (cand <= i) break;
      end
      j = cand;
      for (int r = 0; r < 4; r++) l = lfsr_step(l);
      cyc += 4;
      t = deck[i];
      deck[i] = deck[j];
      deck[j] = t;
    end
    cyc++;
    for (int k = 0; k < n; k++) img[k*8 +: 8] = 8'(deck[k]);
  endtask

  task automatic clear_ram();
    ram_clr = 1'b1;
    @(negedge clk);
    ram_clr = 1'b0;
  endtask

  // Pulse start on the 52-card instance and wait for done; optional stray starts.
  task automatic do_run(input logic [15:0] s, input bit mid, output int cyc, output bit got_done);
    wr_cnt = 0; done_cnt = 0; viol_cnt = 0;
    seed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    got_done = 1'b0;
    check("busy_rise", busy, 1);
    while (cyc < BUDGET) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      start = mid && (cyc == 10 || cyc == 200);
      @(negedge clk);
      cyc++;
    end
    check("done_seen", got_done, 1);
    if (got_done) check("busy_in_done", busy, 0);
    if (mid && got_done) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("start_in_done_ignored", busy, 0);
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic int perm_errors(input logic [2047:0] img, input int n, input int upper_nz);
    int cnt [256];
    int errs;
    errs = upper_nz;
    for (int k = 0; k < n; k++) cnt[k] = 0;
    for (int k = 0; k < n; k++) begin
      if (int'(img[k*8 +: 8]) < n) cnt[int'(img[k*8 +: 8])]++;
      else errs++;
    end
    for (int k = 0; k < n; k++) if (cnt[k] != 1) errs++;
    return errs;
  endfunction

  typedef struct {
    logic [15:0]   seed;
    bit            mid;
    int            exp_cycles;
    logic [2047:0] exp_img;
  } vec_t;

  vec_t          vecs [NVEC];
  logic [2047:0] got_img [NVEC];
  int            got_cyc [NVEC];
  logic [31:0]   exp_q [$];

  initial begin
    int cyc, mism, upper, ec;
    bit gd, prev_wen, hit;
    logic [2047:0] eimg;

    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; seed = '0; seed2 = '0; ram_clr = 1'b0;

    // Table: seeds with their model-derived cycle counts and final images.
    vecs[0].seed = 16'h1234; vecs[0].mid = 1'b0;
    vecs[1].seed = 16'h1234; vecs[1].mid = 1'b0;
    vecs[2].seed = 16'h4321; vecs[2].mid = 1'b0;
    vecs[3].seed = 16'h0000; vecs[3].mid = 1'b0;
    vecs[4].seed = 16'hACE1; vecs[4].mid = 1'b0;
    vecs[5].seed = 16'h1234; vecs[5].mid = 1'b1;
    vecs[6].seed = 16'($urandom_range(1, 65535)); vecs[6].mid = 1'b0;
    vecs[7].seed = 16'($urandom_range(1, 65535)); vecs[7].mid = 1'b1;
    vecs[8].seed = 16'hFFFF; vecs[8].mid = 1'b0;
    for (int v = 0; v < NVEC; v++) model_run(vecs[v].seed, N, vecs[v].exp_cycles, vecs[v].exp_img);

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wen", wen, 0);
    check("reset_addr", addr, 0);
    check("reset_addr2", addr2, 0);
    check("reset_din", din, 0);
    check("reset_busy_n2", busy_b, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NVEC; v++) begin
      clear_ram();
      do_run(vecs[v].seed, vecs[v].mid, cyc, gd);
      got_cyc[v] = cyc;
      check($sformatf("cycles_row%0d", v), cyc, vecs[v].exp_cycles);
      check($sformatf("min_cycles_row%0d", v), (cyc >= 308) ? 1 : 0, 1);
      check($sformatf("done_pulses_row%0d", v), done_cnt, 1);
      check($sformatf("writes_row%0d", v), wr_cnt, N + 2 * (N - 1));
      check($sformatf("idle_bus_row%0d", v), viol_cnt, 0);
      for (int k = 0; k < N; k++) exp_q.push_back(32'(vecs[v].exp_img[k*8 +: 8]));
      mism = 0; upper = 0; got_img[v] = '0;
      for (int k = 0; k < N; k++) begin
        if (ram[k] !== exp_q.pop_front()) mism++;
        if (ram[k][31:8] != 0) upper++;
        got_img[v][k*8 +: 8] = ram[k][7:0];
      end
      check($sformatf("ram_image_row%0d", v), mism, 0);
      check($sformatf("permutation_row%0d", v), perm_errors(got_img[v], N, upper), 0);
    end

    check("same_seed_same_image", (got_img[1] == got_img[0]) ? 1 : 0, 1);
    check("other_seed_differs", (got_img[2] != got_img[0]) ? 1 : 0, 1);
    check("seed0_eq_ace1", (got_img[3] == got_img[4]) ? 1 : 0, 1);
    check("stray_start_same_cycles", got_cyc[5], got_cyc[0]);
    check("stray_start_same_image", (got_img[5] == got_img[0]) ? 1 : 0, 1);

    // Reset for one cycle during the first swap write (WR_I).
    clear_ram();
    done_cnt = 0;
    seed = 16'h5A5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; prev_wen = 1'b1; hit = 1'b0;
    while (cyc < BUDGET) begin
      if (cyc > N && wen && !prev_wen) begin
        hit = 1'b1;
        break;
      end
      prev_wen = wen;
      @(negedge clk);
      cyc++;
    end
    check("wr_i_found", hit, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midreset_busy", busy, 0);
    check("midreset_wen", wen, 0);
    check("midreset_done", done, 0);
    repeat (20) @(negedge clk);
    check("midreset_no_done", done_cnt, 0);
    model_run(16'hBEEF, N, ec, eimg);
    clear_ram();
    do_run(16'hBEEF, 1'b0, cyc, gd);
    check("after_reset_cycles", cyc, ec);
    mism = 0; upper = 0;
    for (int k = 0; k < N; k++) begin
      if (ram[k] !== 32'(eimg[k*8 +: 8])) mism++;
      if (ram[k][31:8] != 0) upper++;
    end
    check("after_reset_image", mism, 0);
    check("after_reset_perm", perm_errors(eimg, N, upper), 0);

    // Two-card instance at a non-zero base address.
    wr_cnt2 = 0; done_cnt2 = 0; viol_cnt2 = 0;
    seed2 = 16'($urandom_range(0, 65535));
    model_run(seed2, N2, ec, eimg);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("n2_fill0_wen", wen_b, 1);
    check("n2_fill0_addr", addr_b, BASE2);
    check("n2_fill0_data", din_b, 0);
    @(negedge clk);
    check("n2_fill1_wen", wen_b, 1);
    check("n2_fill1_addr", addr_b, BASE2 + 1);
    check("n2_fill1_data", din_b, 1);
    cyc = 2; gd = 1'b0;
    while (cyc < BUDGET) begin
      if (done_b) begin
        gd = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check("n2_done_seen", gd, 1);
    check("n2_cycles", cyc, ec);
    check("n2_min_cycles", (cyc >= 8) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    check("n2_done_pulses", done_cnt2, 1);
    check("n2_writes", wr_cnt2, 4);
    check("n2_idle_bus", viol_cnt2, 0);
    check("n2_slot0", ram2[BASE2], 32'(eimg[7:0]));
    check("n2_slot1", ram2[BASE2 + 1], 32'(eimg[15:8]));
    check("n2_perm", ((ram2[BASE2] == 0 && ram2[BASE2 + 1] == 1) ||
                      (ram2[BASE2] == 1 && ram2[BASE2 + 1] == 0)) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
